hamming_frame_tx: RTL and testbench

- Transmit-side companion of the matrix-determinant datapath. Accepts a frame of raw 11-bit signed words plus one 5-bit mode.
- Hamming-encodes the words to 15-bit codewords and the mode to a 9-bit codeword.
- Optionally injects one single-bit error per codeword, buffers the frame, then streams it out as a burst of consecutive beats. This is the protocol consumed by the determinant calculator's in_valid/in_data/in_mode inputs.

---
 rtl/hamming_frame_tx.sv | 159 +++++++++++++++
 tb/tb_hamming_frame_tx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_frame_tx.sv
// -----------------------------------------------------------------------------
// hamming_frame_tx
//
// Transmit-side framer for the matrix-determinant datapath. Collects a frame of
// FRAME_LEN raw 11-bit words plus one 5-bit mode value. Each word is
// Hamming(15,11) encoded and the mode is Hamming(9,5) encoded, both with even
// parity. An optional single-bit error can be injected per codeword. The frame
// is buffered and then replayed as one gap-free burst.
//
// Codeword bit layout: position p (1-based, parity at 1,2,4,8) sits at
// out_data[15-p] / out_mode[9-p].
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous, active-high reset
//   up_valid     upstream word valid
//   up_ready     block accepts a word this cycle (high in LOAD, low in SEND)
//   up_data      raw 11-bit word
//   up_mode      raw 5-bit mode, sampled with word 0 only
//   up_err_pos   0 = clean, 1..15 = flip that data-codeword position
//   up_mode_err  0 = clean, 1..9 = flip that mode-codeword position, 10..15 = clean
//   out_valid    burst beat valid
//   out_data     15-bit data codeword (0 when out_valid is low)
//   out_mode     9-bit mode codeword on beat 0, 0 otherwise
//   busy         high from the first accepted word through the last beat
//   dbg_state    current FSM state (0 = LOAD, 1 = SEND)
//
// Handshake: an upstream word moves on every rising edge where
// up_valid && up_ready. up_ready is a pure decode of the state flop, so it
// never depends combinationally on up_valid. The downstream side has no
// backpressure: once out_valid rises it stays high for FRAME_LEN cycles.
// -----------------------------------------------------------------------------
module hamming_frame_tx #(
  parameter int FRAME_LEN = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        up_valid,
  output logic        up_ready,
  input  logic [10:0] up_data,
  input  logic [4:0]  up_mode,
  input  logic [3:0]  up_err_pos,
  input  logic [3:0]  up_mode_err,
  output logic        out_valid,
  output logic [14:0] out_data,
  output logic [8:0]  out_mode,
  output logic        busy,
  output logic        dbg_state
);

  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  typedef enum logic {
    LOAD = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t        state, next_state;
  logic [CW-1:0] cnt;
  logic [8:0]    mode_reg;
  logic [14:0]   buffer [FRAME_LEN];
  logic          accept;
  logic [14:0]   enc_word;
  logic [8:0]    enc_mode;

  // Codeword order is {p1,p2,d10,p4,d9,d8,d7,p8,d6..d0}.
  function automatic logic [14:0] encode_data(input logic [10:0] d);
    logic p1, p2, p4, p8;
    p1 = d[10] ^ d[9] ^ d[7] ^ d[6] ^ d[4] ^ d[2] ^ d[0];
    p2 = d[10] ^ d[8] ^ d[7] ^ d[5] ^ d[4] ^ d[1] ^ d[0];
    p4 = d[9]  ^ d[8] ^ d[7] ^ d[3] ^ d[2] ^ d[1] ^ d[0];
    p8 = d[6]  ^ d[5] ^ d[4] ^ d[3] ^ d[2] ^ d[1] ^ d[0];
    return {p1, p2, d[10], p4, d[9], d[8], d[7], p8, d[6:0]};
  endfunction

  // Codeword order is {p1,p2,m4,p4,m3,m2,m1,p8,m0}.
  function automatic logic [8:0] encode_mode(input logic [4:0] m);
    logic p1, p2, p4, p8;
    p1 = m[4] ^ m[3] ^ m[1] ^ m[0];
    p2 = m[4] ^ m[2] ^ m[1];
    p4 = m[3] ^ m[2] ^ m[1];
    p8 = m[0];
    return {p1, p2, m[4], p4, m[3], m[2], m[1], p8, m[0]};
  endfunction

  // Position p lives at bit (15-p): position 1 is the MSB, so shift down from it.
  function automatic logic [14:0] data_flip(input logic [3:0] pos);
    if (pos == 4'd0) return 15'h0000;
    return 15'h4000 >> (pos - 4'd1);
  endfunction

  function automatic logic [8:0] mode_flip(input logic [3:0] pos);
    if (pos == 4'd0 || pos > 4'd9) return 9'h000;
    return 9'h100 >> (pos - 4'd1);
  endfunction

  assign accept   = up_valid && (state == LOAD);
  assign enc_word = encode_data(up_data) ^ data_flip(up_err_pos);
  assign enc_mode = encode_mode(up_mode) ^ mode_flip(up_mode_err);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= next_state;
  end

  // Next state and all outputs, decoded from registered state.
  always_comb begin
    next_state = state;
    up_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = 15'h0000;
    out_mode   = 9'h000;
    busy       = 1'b0;
    dbg_state  = state;
    case (state)
      LOAD: begin
        up_ready = 1'b1;
        // cnt != 0 means word 0 has been taken: busy from accept+1 onward.
        busy     = (cnt != '0);
        if (accept && cnt == LAST) next_state = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_data  = buffer[cnt];
        out_mode  = (cnt == '0) ? mode_reg : 9'h000;
        if (cnt == LAST) next_state = LOAD;
      end
      default: next_state = LOAD;
    endcase
  end

  // Word counter (load index in LOAD, beat index in SEND) and mode register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      mode_reg <= 9'h000;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            if (cnt == '0) mode_reg <= enc_mode;
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
          end
        end
        SEND: cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        default: cnt <= '0;
      endcase
    end
  end

  // Frame buffer; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (!rst && accept) buffer[cnt] <= enc_word;
  end

endmodule

// File: tb/tb_hamming_frame_tx.sv
module tb_hamming_frame_tx;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // 16-word instance
  logic        up_valid, up_ready, out_valid, busy, dbg_state;
  logic [10:0] up_data;
  logic [4:0]  up_mode;
  logic [3:0]  up_err_pos, up_mode_err;
  logic [14:0] out_data;
  logic [8:0]  out_mode;

  // 4-word instance
  logic        up_valid_4, up_ready_4, out_valid_4, busy_4, dbg_state_4;
  logic [10:0] up_data_4;
  logic [4:0]  up_mode_4;
  logic [3:0]  up_err_pos_4, up_mode_err_4;
  logic [14:0] out_data_4;
  logic [8:0]  out_mode_4;

  hamming_frame_tx #(.FRAME_LEN(16)) dut (
    .clk(clk), .rst(rst),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
    .up_mode(up_mode), .up_err_pos(up_err_pos), .up_mode_err(up_mode_err),
    .out_valid(out_valid), .out_data(out_data), .out_mode(out_mode),
    .busy(busy), .dbg_state(dbg_state)
  );

  hamming_frame_tx #(.FRAME_LEN(4)) dut4 (
    .clk(clk), .rst(rst),
    .up_valid(up_valid_4), .up_ready(up_ready_4), .up_data(up_data_4),
    .up_mode(up_mode_4), .up_err_pos(up_err_pos_4), .up_mode_err(up_mode_err_4),
    .out_valid(out_valid_4), .out_data(out_data_4), .out_mode(out_mode_4),
    .busy(busy_4), .dbg_state(dbg_state_4)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [14:0] exp_q[$];
  logic [10:0] w_data [16];
  logic [3:0]  w_err  [16];
  logic [14:0] w_exp  [16];
  logic [10:0] pat_v  [6];
  logic [14:0] pat_e  [6];
  logic [14:0] beat_exp;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"},  out_data, 0);
    chk({tag, "_out_mode"},  out_mode, 0);
    chk({tag, "_busy"},      busy, 0);
    chk({tag, "_up_ready"},  up_ready, 1);
  endtask

  // ---------------- driver ----------------
  task automatic load_frame(input int max_gap, input logic [4:0] mode, input logic [3:0] merr);
    int gap;
    for (int i = 0; i < 16; i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int g = 0; g < gap; g++) begin
        up_valid    = 1'b0;
        up_data     = 11'($urandom);
        up_err_pos  = 4'($urandom);
        up_mode     = 5'($urandom);
        up_mode_err = 4'($urandom);
        tick();
        chk($sformatf("gap_w%0d_ready", i), up_ready, 1);
        chk($sformatf("gap_w%0d_valid", i), out_valid, 0);
      end
      up_valid    = 1'b1;
      up_data     = w_data[i];
      up_err_pos  = w_err[i];
      up_mode     = (i == 0) ? mode : 5'($urandom);
      up_mode_err = (i == 0) ? merr : 4'($urandom);
      exp_q.push_back(w_exp[i]);
      tick();
      if (i == 0)  chk("busy_after_w0", busy, 1);
      if (i == 14) chk("no_early_beat", out_valid, 0);
    end
    up_valid = 1'b0;
  endtask

  // Beat 0 must already be present one cycle after the last accept.
  task automatic check_burst(input string tag, input logic [8:0] exp_mode);
    for (int b = 0; b < 16; b++) begin
      if (b > 0) tick();
      beat_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 15'h0000;
      chk($sformatf("%s_b%0d_valid", tag, b), out_valid, 1);
      chk($sformatf("%s_b%0d_data", tag, b), out_data, beat_exp);
      chk($sformatf("%s_b%0d_mode", tag, b), out_mode, (b == 0) ? exp_mode : 9'h000);
      chk($sformatf("%s_b%0d_ready", tag, b), up_ready, 0);
      chk($sformatf("%s_b%0d_busy", tag, b), busy, 1);
      // Junk offered during SEND must be ignored.
      up_valid    = 1'b1;
      up_data     = 11'($urandom);
      up_err_pos  = 4'($urandom);
      up_mode     = 5'($urandom);
      up_mode_err = 4'($urandom);
    end
    up_valid = 1'b0;
    tick();
    idle_checks({tag, "_end"});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    pat_v = '{11'h7FF, 11'h001, 11'h400, 11'h040, 11'h555, 11'h000};
    pat_e = '{15'h7FFF, 15'h6881, 15'h7000, 15'h40C0, 15'h5A55, 15'h0000};

    rst = 1'b1;
    up_valid = 0; up_data = 0; up_mode = 0; up_err_pos = 0; up_mode_err = 0;
    up_valid_4 = 0; up_data_4 = 0; up_mode_4 = 0; up_err_pos_4 = 0; up_mode_err_4 = 0;

    // Reset state
    tick();
    idle_checks("reset");
    chk("reset_dbg_state", dbg_state, 0);
    tick();
    rst = 1'b0;

    // Zero words, mode 1F
    for (int i = 0; i < 16; i++) begin
      w_data[i] = 11'h000; w_err[i] = 4'd0; w_exp[i] = 15'h0000;
    end
    load_frame(0, 5'h1F, 4'd0);
    check_burst("zero", 9'h0FF);

    // Alternating 7FF / 001; mode 0 with flip at position 9
    for (int i = 0; i < 16; i++) begin
      w_data[i] = (i % 2 == 0) ? 11'h7FF : 11'h001;
      w_err[i]  = 4'd0;
      w_exp[i]  = (i % 2 == 0) ? 15'h7FFF : 15'h6881;
    end
    load_frame(0, 5'h00, 4'd9);
    check_burst("alt", 9'h001);

    // Error injection on zero words; mode error 12 is ignored
    for (int i = 0; i < 16; i++) begin
      w_data[i] = 11'h000; w_err[i] = 4'd0; w_exp[i] = 15'h0000;
    end
    w_err[0] = 4'd3;  w_exp[0] = 15'h1000;
    w_err[1] = 4'd15; w_exp[1] = 15'h0001;
    w_err[2] = 4'd8;  w_exp[2] = 15'h0080;
    w_err[3] = 4'd1;  w_exp[3] = 15'h4000;
    load_frame(0, 5'h00, 4'd12);
    check_burst("err", 9'h000);

    // Random upstream gaps; mode 01 with flip at position 3 (103 ^ 040)
    for (int i = 0; i < 16; i++) begin
      w_data[i] = pat_v[i % 6]; w_err[i] = 4'd0; w_exp[i] = pat_e[i % 6];
    end
    load_frame(5, 5'h01, 4'd3);
    check_burst("gaps", 9'h143);

    // Reset on beat 7 of a burst
    for (int i = 0; i < 16; i++) begin
      w_data[i] = 11'h7FF; w_err[i] = 4'd0; w_exp[i] = 15'h7FFF;
    end
    load_frame(0, 5'h1F, 4'd0);
    for (int b = 0; b < 7; b++) tick();
    chk("pre_rst_beat7_valid", out_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    idle_checks("mid_rst");
    tick();
    chk("mid_rst_stays_idle", out_valid, 0);

    // Frame after reset carries its own mode (15 -> 06B)
    for (int i = 0; i < 16; i++) begin
      w_data[i] = pat_v[(i + 4) % 6]; w_err[i] = 4'd0; w_exp[i] = pat_e[(i + 4) % 6];
    end
    load_frame(0, 5'h15, 4'd0);
    check_burst("post_rst", 9'h06B);

    // FRAME_LEN = 4 instance
    chk("f4_idle_ready", up_ready_4, 1);
    chk("f4_idle_busy", busy_4, 0);
    for (int i = 0; i < 4; i++) begin
      up_valid_4 = 1'b1;
      up_data_4  = pat_v[(i + 4) % 6];
      up_mode_4  = (i == 0) ? 5'h15 : 5'h00;
      exp_q.push_back(pat_e[(i + 4) % 6]);
      tick();
      chk($sformatf("f4_w%0d_busy", i), busy_4, 1);
    end
    up_valid_4 = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (b > 0) tick();
      beat_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 15'h0000;
      chk($sformatf("f4_b%0d_valid", b), out_valid_4, 1);
      chk($sformatf("f4_b%0d_data", b), out_data_4, beat_exp);
      chk($sformatf("f4_b%0d_mode", b), out_mode_4, (b == 0) ? 9'h06B : 9'h000);
      chk($sformatf("f4_b%0d_busy", b), busy_4, 1);
      chk($sformatf("f4_b%0d_ready", b), up_ready_4, 0);
    end
    tick();
    chk("f4_end_valid", out_valid_4, 0);
    chk("f4_end_data", out_data_4, 0);
    chk("f4_end_busy", busy_4, 0);
    chk("f4_end_ready", up_ready_4, 1);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
